ntable_loader: RTL
==================

// Module: ntable_loader
// PURPOSE
//  Writer side of the 1 KiB NES name table RAM that the background renderer reads.
//  - Accepts bytes from the UART receiver and writes 960 tile indices plus 64 attribute bytes sequentially.
//  - Drives the write port of the dual-port name table RAM; the renderer keeps the read port.
// PARAMETERS
//  C_MEMW     8        data width of name table RAM
//  C_AW       10       name table address width (1 KiB)
//  C_NBYTES   1024     bytes per full load/fill; must be <= 2**C_AW
//  C_SYNC     8'hA5    command byte that starts a load
//  C_CLR      8'h5A    command byte that starts a fill (only with NTABLE_CLR_EN)
//  C_TIMEOUT  1000000  clk cycles allowed between bytes inside a transfer
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous reset, ACTIVE LOW
//  rx_dato         in   C_MEMW  byte from UART receiver, valid when rx_listo=1
//  rx_listo        in   1       one-cycle strobe, new byte on rx_dato
//  addr_ntable_wr  out  C_AW    name table write address
//  d_ntable_wr     out  C_MEMW  name table write data
//  we_ntable       out  1       write enable, one cycle per byte
//  cargando        out  1       1 while a load or fill is in progress
//  fin             out  1       one-cycle pulse, transfer completed
//  error           out  1       sticky, a timeout aborted a transfer
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, byte counter=0, timeout counter=0, all outputs 0.
//  All outputs are registered.
//  States: IDLE, LOAD, CLR_WAIT, FILL.
//  IDLE
//   - rx_listo with rx_dato==C_SYNC -> LOAD; counter=0, error<=0.
//   - Any other byte is ignored; no write occurs.
//  LOAD
//   - Each rx_listo: one cycle later we_ntable=1, addr_ntable_wr=counter, d_ntable_wr=rx_dato.
//   - Counter then increments.
//   - The write of index C_NBYTES-1 returns to IDLE; fin=1 in that same cycle.
//   - A C_SYNC byte inside LOAD is data, not a restart.
//  Timeout
//   - In LOAD/CLR_WAIT the timeout counter clears on every rx_listo and increments otherwise.
//   - At C_TIMEOUT-1 without a byte: -> IDLE, error<=1, no fin, no write.
//   - Bytes already written stay in RAM.
//  Other rules
//   - cargando=1 in every state except IDLE.
//   - we_ntable is 0 on every cycle without a write; addr/data hold their last value.
//   - Counter width C_AW+1, so C_NBYTES=2**C_AW is reached without wrap.
//   - Address is counter[C_AW-1:0].
//   - rx_listo on the same cycle the timeout expires: the byte wins; no timeout.
//   - Reset mid-transfer aborts immediately; partial RAM contents are left as written.
// CONFIGURATION
//  NTABLE_CLR_EN defined:
//   - In IDLE, rx_dato==C_CLR -> CLR_WAIT; error<=0.
//   - The next byte is the fill value -> FILL.
//   - FILL writes the fill value to addresses 0..C_NBYTES-1, one per clk, we_ntable=1 continuously.
//   - rx_listo is ignored during FILL; no timeout applies in FILL.
//   - fin pulses on the cycle of the last write, then -> IDLE.
//  NTABLE_CLR_EN undefined:
//   - CLR_WAIT and FILL are not built.
//   - C_CLR is an ordinary ignored byte in IDLE.
// STRUCTURE
//  Shared include ntable_defs.vh:
//   - state encodings (IDLE=0, LOAD=1, CLR_WAIT=2, FILL=3)
//   - C_SYNC/C_CLR defaults
//   - name table geometry (32x30 tiles, attribute base 10'h3C0)
//  One sub-module, cnt_timeout:
//   - clear / enable inputs, terminal-count output, parameter C_TIMEOUT.
//  FSM, byte counter and write register stay in ntable_loader.
// TESTING (use C_TIMEOUT=50, C_NBYTES=1024)
//  1 Sync A5, then bytes k&8'hFF for k=0..1023 -> 1024 single we pulses; RAM[k]==k&FF; fin once after addr 3FF; cargando 0 after.
//  2 Bytes 00,13,A4 in IDLE -> no we_ntable, cargando=0, fin=0.
//  3 Sync, 10 bytes, then 60 idle cycles -> error=1 at cycle 49 after last byte; IDLE; RAM[0..9] written.
//    Next A5 clears error.
//  4 Sync, 500 bytes, rst=0 for 1 cycle -> all outputs 0.
//    New full load then completes normally.
//  5 (NTABLE_CLR_EN) 5A, 24 -> 1024 consecutive we cycles, addr 000..3FF, data 24, fin on last.
//    Bytes sent during FILL are not written.
//  6 rx_listo on the exact timeout-expiry cycle -> byte written, no error.

Source files
------------

// File: rtl/ntable_loader_pkg.sv
// Shared definitions for the name table loader: state encoding, command byte
// defaults, parameter defaults and NES name table geometry.
package ntable_loader_pkg;

   localparam int          C_MEMW_DEF    = 8;
   localparam int          C_AW_DEF      = 10;
   localparam int          C_NBYTES_DEF  = 1024;
   localparam int          C_TIMEOUT_DEF = 1000000;
   localparam logic [7:0]  C_SYNC_DEF    = 8'hA5;
   localparam logic [7:0]  C_CLR_DEF     = 8'h5A;

   // 32x30 tiles; the attribute table follows the tile indices directly.
   localparam int          NT_COLS       = 32;
   localparam int          NT_ROWS       = 30;
   localparam logic [9:0]  NT_ATTR_BASE  = 10'(NT_COLS * NT_ROWS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_CLR_WAIT = 2'd2,
      ST_FILL     = 2'd3
   } state_t;

endpackage

// File: rtl/ntable_loader_if.sv
// UART byte input and name table write port of the loader, bundled as one
// interface; the loader side uses the slave modport.
interface ntable_loader_if #(
   parameter int C_MEMW = 8,
   parameter int C_AW   = 10
);
   logic [C_MEMW-1:0] rx_dato;
   logic              rx_listo;
   logic [C_AW-1:0]   addr_ntable_wr;
   logic [C_MEMW-1:0] d_ntable_wr;
   logic              we_ntable;
   logic              cargando;
   logic              fin;
   logic              error;

   modport master (
      output rx_dato, rx_listo,
      input  addr_ntable_wr, d_ntable_wr, we_ntable, cargando, fin, error
   );

   modport slave (
      input  rx_dato, rx_listo,
      output addr_ntable_wr, d_ntable_wr, we_ntable, cargando, fin, error
   );
endinterface

// File: rtl/ntable_loader_cnt_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, clears on request,
// and flags the terminal count (C_TIMEOUT-1) until cleared.
module ntable_loader_cnt_timeout #(
   parameter int C_TIMEOUT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam int W = $clog2(C_TIMEOUT + 1);

   logic [W-1:0] cnt_q;

   assign tc_o = (cnt_q == W'(C_TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !tc_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/ntable_loader.sv
// Writer side of the NES name table RAM: loads C_NBYTES bytes from the UART
// after a sync byte. Optional fill command built only with NTABLE_CLR_EN.
//
// state       | meaning
// ST_IDLE     | waiting for a command byte
// ST_LOAD     | each received byte is written at the next address
// ST_CLR_WAIT | fill command seen, waiting for the fill value
// ST_FILL     | writing the fill value to every address, one per clk
module ntable_loader
   import ntable_loader_pkg::*;
#(
   parameter int              C_MEMW    = C_MEMW_DEF,
   parameter int              C_AW      = C_AW_DEF,
   parameter int              C_NBYTES  = C_NBYTES_DEF,
   parameter int              C_TIMEOUT = C_TIMEOUT_DEF,
   parameter logic [C_MEMW-1:0] C_SYNC  = C_MEMW'(C_SYNC_DEF)
`ifdef NTABLE_CLR_EN
   ,parameter logic [C_MEMW-1:0] C_CLR  = C_MEMW'(C_CLR_DEF)
`endif
) (
   input  logic         clk,
   input  logic         rst,
   ntable_loader_if.slave bus
);
   localparam logic [C_AW:0] LAST = (C_AW+1)'(C_NBYTES - 1);

   state_t            state_q;
   logic [C_AW:0]     cnt_q;
   logic [C_AW-1:0]   addr_q;
   logic [C_MEMW-1:0] data_q;
   logic              we_q;
   logic              carg_q;
   logic              fin_q;
   logic              err_q;
`ifdef NTABLE_CLR_EN
   logic [C_MEMW-1:0] fill_q;
`endif

   logic tmo_en, tmo_clr, tmo_tc;

   // A byte arriving on the expiry cycle clears the watchdog, so it wins.
   assign tmo_en  = (state_q == ST_LOAD) || (state_q == ST_CLR_WAIT);
   assign tmo_clr = bus.rx_listo || !tmo_en;

   ntable_loader_cnt_timeout #(.C_TIMEOUT(C_TIMEOUT)) u_tmo (
      .clk   (clk),
      .rst   (rst),
      .clr_i (tmo_clr),
      .en_i  (tmo_en),
      .tc_o  (tmo_tc)
   );

   assign bus.addr_ntable_wr = addr_q;
   assign bus.d_ntable_wr    = data_q;
   assign bus.we_ntable      = we_q;
   assign bus.cargando       = carg_q;
   assign bus.fin            = fin_q;
   assign bus.error          = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         carg_q  <= 1'b0;
         fin_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef NTABLE_CLR_EN
         fill_q  <= '0;
`endif
      end else begin
         we_q  <= 1'b0;
         fin_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.rx_listo) begin
                  if (bus.rx_dato == C_SYNC) begin
                     state_q <= ST_LOAD;
                     cnt_q   <= '0;
                     err_q   <= 1'b0;
                     carg_q  <= 1'b1;
                  end
`ifdef NTABLE_CLR_EN
                  else if (bus.rx_dato == C_CLR) begin
                     state_q <= ST_CLR_WAIT;
                     err_q   <= 1'b0;
                     carg_q  <= 1'b1;
                  end
`endif
               end
            end
            ST_LOAD: begin
               if (bus.rx_listo) begin
                  we_q   <= 1'b1;
                  addr_q <= cnt_q[C_AW-1:0];
                  data_q <= bus.rx_dato;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     fin_q   <= 1'b1;
                     state_q <= ST_IDLE;
                     carg_q  <= 1'b0;
                  end
               end else if (tmo_tc) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                  carg_q  <= 1'b0;
               end
            end
`ifdef NTABLE_CLR_EN
            ST_CLR_WAIT: begin
               if (bus.rx_listo) begin
                  fill_q  <= bus.rx_dato;
                  cnt_q   <= '0;
                  state_q <= ST_FILL;
               end else if (tmo_tc) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
                  carg_q  <= 1'b0;
               end
            end
            ST_FILL: begin
               we_q   <= 1'b1;
               addr_q <= cnt_q[C_AW-1:0];
               data_q <= fill_q;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  fin_q   <= 1'b1;
                  state_q <= ST_IDLE;
                  carg_q  <= 1'b0;
               end
            end
`endif
            default: begin
               state_q <= ST_IDLE;
               carg_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule
